bash_line_input: RTL and testbench

Keyboard-to-bash line assembler sitting directly upstream of the command/echo consumer. Collects decoded ASCII keystrokes into a 32-entry line buffer with local echo and backspace editing, then streams the completed line to the consumer one character per handshake, terminated by 8'h00. Input is only accepted after the consumer raises `in_require_line`; `out_require_line` acknowledges the request.

---
 rtl/bash_line_input.sv | 121 ++++++++++++
 tb/tb_bash_line_input.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_line_input.sv
// Keyboard line assembler: collects keystrokes into a line buffer with local
// echo and backspace editing, then streams the line to the consumer, ending with 8'h00.
module bash_line_input #(
    parameter int MAX_LEN = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_ascii,
    input  logic       in_require_line,
    output logic       out_require_line,
    output logic       echo_valid,
    output logic [7:0] echo_ascii,
    output logic       out_newASCII_ready,
    output logic [5:0] out_lineLen,
    output logic [7:0] lineOut,
    input  logic       lineOut_nextASCII
);
    localparam int DEPTH = MAX_LEN + 1;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EDIT, SEND} state_t;

    state_t     state_reg, state_next;
    logic [5:0] len_reg, len_next;
    logic [5:0] rd_ptr_reg, rd_ptr_next;
    logic       ack_reg, ack_next;
    logic       echo_valid_reg, echo_valid_next;
    logic [7:0] echo_ascii_reg, echo_ascii_next;
    logic       wr_en;
    logic       is_print;
    logic [7:0] line_buf [DEPTH];

    assign is_print = (kbd_ascii >= 8'h20) && (kbd_ascii <= 8'h7E);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            rd_ptr_reg     <= '0;
            ack_reg        <= 1'b0;
            echo_valid_reg <= 1'b0;
            echo_ascii_reg <= '0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            rd_ptr_reg     <= rd_ptr_next;
            ack_reg        <= ack_next;
            echo_valid_reg <= echo_valid_next;
            echo_ascii_reg <= echo_ascii_next;
        end
    end

    // Buffer contents need no reset; only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[len_reg[AW-1:0]] <= kbd_ascii;
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        rd_ptr_next     = rd_ptr_reg;
        ack_next        = 1'b0;
        echo_valid_next = 1'b0;
        echo_ascii_next = echo_ascii_reg;
        wr_en           = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (in_require_line) begin
                    ack_next    = 1'b1;
                    len_next    = '0;
                    rd_ptr_next = '0;
                    state_next  = EDIT;
                end
            end
            EDIT: begin
                if (kbd_valid) begin
                    if (is_print) begin
                        if (len_reg < 6'(MAX_LEN)) begin
                            wr_en           = 1'b1;
                            len_next        = len_reg + 6'd1;
                            echo_valid_next = 1'b1;
                            echo_ascii_next = kbd_ascii;
                        end
                    end else if (kbd_ascii == 8'h08) begin
                        if (len_reg != '0) begin
                            len_next        = len_reg - 6'd1;
                            echo_valid_next = 1'b1;
                            echo_ascii_next = 8'h08;
                        end
                    end else if (kbd_ascii == 8'h0D || kbd_ascii == 8'h0A) begin
                        echo_valid_next = 1'b1;
                        echo_ascii_next = 8'h0A;
                        rd_ptr_next     = '0;
                        state_next      = SEND;
                    end
                end
            end
            SEND: begin
                if (lineOut_nextASCII) begin
                    if (rd_ptr_reg < len_reg) begin
                        rd_ptr_next = rd_ptr_reg + 6'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_require_line   = ack_reg;
    assign echo_valid         = echo_valid_reg;
    assign echo_ascii         = echo_ascii_reg;
    assign out_newASCII_ready = (state_reg == SEND);
    assign out_lineLen        = (state_reg == SEND) ? len_reg : 6'd0;
    assign lineOut            = (state_reg == SEND && rd_ptr_reg != len_reg)
                                ? line_buf[rd_ptr_reg[AW-1:0]] : 8'h00;
endmodule

// File: tb/tb_bash_line_input.sv
// Scoreboard bench for bash_line_input: a line-level model predicts echoes and
// streamed characters; a negedge monitor pops and compares them.
module tb_bash_line_input;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_ascii = 8'h00;
    logic       in_require_line = 1'b0;
    logic       out_require_line;
    logic       echo_valid;
    logic [7:0] echo_ascii;
    logic       out_newASCII_ready;
    logic [5:0] out_lineLen;
    logic [7:0] lineOut;
    logic       lineOut_nextASCII = 1'b0;

    always #5 clk = ~clk;

    bash_line_input dut (
        .clk               (clk),
        .rst               (rst),
        .kbd_valid         (kbd_valid),
        .kbd_ascii         (kbd_ascii),
        .in_require_line   (in_require_line),
        .out_require_line  (out_require_line),
        .echo_valid        (echo_valid),
        .echo_ascii        (echo_ascii),
        .out_newASCII_ready(out_newASCII_ready),
        .out_lineLen       (out_lineLen),
        .lineOut           (lineOut),
        .lineOut_nextASCII (lineOut_nextASCII)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 editing, 2 sending
    int         mode = 0;
    logic [7:0] model_line[$];
    logic [7:0] echo_q[$];
    logic [7:0] line_q[$];
    int         exp_len = 0;
    bit         pulse_chk = 1'b1;

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (echo_valid) begin
                vectors++;
                if (echo_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL echo_unexpected got=%02h want=none t=%0t", echo_ascii, $time);
                end else begin
                    logic [7:0] e;
                    e = echo_q.pop_front();
                    if (echo_ascii !== e) begin
                        miscompares++;
                        $display("FAIL echo got=%02h want=%02h t=%0t", echo_ascii, e, $time);
                    end else
                        $display("echo %02h ok", echo_ascii);
                end
            end
            if (lineOut_nextASCII && pulse_chk) begin
                vectors++;
                if (line_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL line_unexpected got=%02h want=none t=%0t", lineOut, $time);
                end else begin
                    logic [7:0] c;
                    c = line_q.pop_front();
                    if (lineOut !== c || out_lineLen !== 6'(exp_len) || out_newASCII_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL line got=%02h len=%0d rdy=%0b want=%02h len=%0d rdy=1 t=%0t",
                                 lineOut, out_lineLen, out_newASCII_ready, c, exp_len, $time);
                    end else
                        $display("line char %02h len %0d ok", lineOut, out_lineLen);
                end
            end
        end
    end

    task automatic model_key(input logic [7:0] k);
        if (mode != 1) return;
        if (k >= 8'h20 && k <= 8'h7E) begin
            if (model_line.size() < 31) begin
                model_line.push_back(k);
                echo_q.push_back(k);
            end
        end else if (k == 8'h08) begin
            if (model_line.size() > 0) begin
                void'(model_line.pop_back());
                echo_q.push_back(8'h08);
            end
        end else if (k == 8'h0D || k == 8'h0A) begin
            echo_q.push_back(8'h0A);
            foreach (model_line[i]) line_q.push_back(model_line[i]);
            line_q.push_back(8'h00);
            exp_len = model_line.size();
            mode = 2;
        end
    endtask

    task automatic key(input logic [7:0] k);
        kbd_valid = 1'b1;
        kbd_ascii = k;
        model_key(k);
        @(posedge clk); #1;
        kbd_valid = 1'b0;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) key(s[i]);
    endtask

    task automatic request(input bit with_key);
        int n;
        in_require_line = 1'b1;
        if (with_key) begin
            kbd_valid = 1'b1;
            kbd_ascii = 8'h7A;
        end
        n = 0;
        do begin
            @(negedge clk);
            kbd_valid = 1'b0;
            n++;
        end while (!out_require_line && n < 8);
        chk("ack_pulse", out_require_line, 1);
        mode = 1;
        model_line.delete();
        @(posedge clk); #1;
        in_require_line = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", out_require_line, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int max_gap);
        int n, total;
        n = 0;
        while (!out_newASCII_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!out_newASCII_ready) begin
            chk("ready_timeout", 0, 1);
            line_q.delete();
            mode = 0;
            return;
        end
        @(posedge clk); #1;
        total = line_q.size();
        for (int i = 0; i < total; i++) begin
            int g;
            lineOut_nextASCII = 1'b1;
            @(posedge clk); #1;
            g = $urandom_range(max_gap, 0);
            if (g > 0) begin
                lineOut_nextASCII = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
        end
        lineOut_nextASCII = 1'b0;
        mode = 0;
        @(negedge clk);
        chk("ready_drop", out_newASCII_ready, 0);
        chk("echo_q_empty", echo_q.size(), 0);
        chk("line_q_empty", line_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        echo_q.delete();
        line_q.delete();
        model_line.delete();
        mode = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", out_require_line, 0);
        chk("rst_echo_valid", echo_valid, 0);
        chk("rst_echo_ascii", echo_ascii, 0);
        chk("rst_ready", out_newASCII_ready, 0);
        chk("rst_len", out_lineLen, 0);
        chk("rst_lineout", lineOut, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [7:0] junk [7] = '{8'h01, 8'h1B, 8'h7F, 8'h09, 8'h80, 8'hFF, 8'h00};

    initial begin
        do_reset();

        // keys and consumer pulses while idle are ignored
        key(8'h41);
        pulse_chk = 1'b0;
        lineOut_nextASCII = 1'b1;
        @(posedge clk); #1;
        lineOut_nextASCII = 1'b0;
        pulse_chk = 1'b1;

        request(1'b0);
        type_str("ls");
        key(8'h0D);
        key(8'h71);                 // key during SEND is dropped
        drain(1);

        request(1'b1);              // simultaneous key dropped
        type_str("ab");
        key(8'h08); key(8'h08); key(8'h08);
        type_str("c");
        key(8'h0A);
        drain(0);

        request(1'b0);
        for (int i = 0; i < 35; i++) key(8'h78);
        key(8'h0D);
        drain(2);

        request(1'b0);
        key(8'h0D);
        @(negedge clk);
        chk("empty_len", out_lineLen, 0);
        chk("empty_lineout", lineOut, 0);
        drain(0);

        // reset in the middle of streaming "hello"
        request(1'b0);
        type_str("hello");
        key(8'h0D);
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            lineOut_nextASCII = 1'b1;
            @(posedge clk); #1;
        end
        lineOut_nextASCII = 1'b0;
        @(negedge clk);
        chk("echo_before_rst", echo_q.size(), 0);
        @(posedge clk); #1;
        do_reset();
        request(1'b0);
        key(8'h0D);
        drain(0);

        for (int t = 0; t < 25; t++) begin
            int n;
            request($urandom_range(3, 0) == 0);
            n = $urandom_range(40, 0);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(9, 0);
                if (r < 6)      key(8'($urandom_range(126, 32)));
                else if (r < 8) key(8'h08);
                else            key(junk[$urandom_range(6, 0)]);
                if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
            end
            key(($urandom_range(1, 0) == 0) ? 8'h0D : 8'h0A);
            if ($urandom_range(1, 0) == 0) key(8'($urandom_range(126, 32)));
            drain(2);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("final_echo_q", echo_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
